// File: rtl/entrada_tentativa.sv
// Input conditioner for the attempt display stage: synchronizes the ENTER key and switches, debounces the key,
// emits one enter pulse per accepted press and counts attempts. Macro ENTRADA_DEBOUNCE_EN enables the debounce counter.
module entrada_tentativa #(
  parameter int unsigned W               = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned MAX_TENTATIVAS  = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                key_enter_n,
  input  logic [W-1:0]                        sw,
  input  logic                                travar,
  output logic                                enter,
  output logic [W-1:0]                        tentativa,
  output logic [$clog2(MAX_TENTATIVAS+1)-1:0] num_tentativas,
  output logic                                esgotou
);

  localparam int unsigned NW = $clog2(MAX_TENTATIVAS + 1);

  localparam logic [1:0] OCIOSO      = 2'd0;
  localparam logic [1:0] CONF_PRESS  = 2'd1;
  localparam logic [1:0] PRESSIONADO = 2'd2;
  localparam logic [1:0] CONF_SOLTA  = 2'd3;

`ifdef ENTRADA_DEBOUNCE_EN
  localparam int unsigned CW = ($clog2(DEBOUNCE_CYCLES) > 16) ? $clog2(DEBOUNCE_CYCLES) : 16;
  localparam logic [1:0]  RST_STATE = CONF_SOLTA;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
`else
  localparam logic [1:0]  RST_STATE = PRESSIONADO;
`endif

  logic [1:0]   r_key_sync;
  logic [W-1:0] r_sw_meta;
  logic [W-1:0] r_sw_s;
  logic [1:0]   r_state;
  logic [1:0]   w_state_nx;
  logic         w_press;
  logic         w_accept;
  logic         w_key_s;
  logic         r_enter;
  logic [W-1:0] r_tentativa;
  logic [NW-1:0] r_num;

  assign w_key_s = r_key_sync[1];

  // Two-flop synchronizers; the key resets to released so a held key is never seen as a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_sync <= 2'b11;
      r_sw_meta  <= '0;
      r_sw_s     <= '0;
    end else begin
      r_key_sync <= {r_key_sync[0], key_enter_n};
      r_sw_meta  <= sw;
      r_sw_s     <= r_sw_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
`ifdef ENTRADA_DEBOUNCE_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
`ifdef ENTRADA_DEBOUNCE_EN
      r_cnt   <= w_cnt_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_press    = 1'b0;
`ifdef ENTRADA_DEBOUNCE_EN
    w_cnt_nx   = r_cnt;
    case (r_state)
      OCIOSO: begin
        if (!w_key_s) begin
          w_state_nx = CONF_PRESS;
          w_cnt_nx   = '0;
        end
      end
      CONF_PRESS: begin
        if (w_key_s) begin
          w_state_nx = OCIOSO;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          w_state_nx = PRESSIONADO;
          w_press    = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      PRESSIONADO: begin
        if (w_key_s) begin
          w_state_nx = CONF_SOLTA;
          w_cnt_nx   = '0;
        end
      end
      default: begin
        if (!w_key_s) begin
          w_state_nx = PRESSIONADO;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          w_state_nx = OCIOSO;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
    endcase
`else
    case (r_state)
      OCIOSO: begin
        if (!w_key_s) begin
          w_state_nx = PRESSIONADO;
          w_press    = 1'b1;
        end
      end
      PRESSIONADO: begin
        if (w_key_s) w_state_nx = OCIOSO;
      end
      default: w_state_nx = PRESSIONADO;
    endcase
`endif
  end

  // Lock or exhausted limit suppress the accept but never stall the FSM.
  assign w_accept = w_press & ~travar & ~esgotou;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enter     <= 1'b0;
      r_tentativa <= '0;
      r_num       <= '0;
    end else begin
      r_enter <= w_accept;
      if (w_accept) begin
        r_tentativa <= r_sw_s;
        r_num       <= r_num + NW'(1);
      end
    end
  end

  assign enter          = r_enter;
  assign tentativa      = r_tentativa;
  assign num_tentativas = r_num;
  assign esgotou        = (r_num == NW'(MAX_TENTATIVAS));

endmodule

// File: doc/entrada_tentativa.md
# entrada_tentativa

Input conditioner that sits directly upstream of the attempt display stage: synchronizes the raw ENTER push-button and attempt switches, debounces the button, emits exactly one single-cycle `enter` pulse per physical press together with a stable registered copy of the switches, and counts attempts up to a configured limit. Its `enter` and `tentativa` outputs drive the display stage's `enter` and `sw_tentativa` inputs.

## Interface
- `W`, 6: attempt width in bits (SW[W-1:0]).
- `DEBOUNCE_CYCLES`, 1000000: stable cycles required to accept a press or release (20 ms at 50 MHz); must be ≥ 2.
- `MAX_TENTATIVAS`, 10: attempt limit; must be ≥ 1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `key_enter_n`  in  1  raw ENTER button (KEY[3]), active-low, asynchronous, bouncing.
- `sw`  in  W  raw switches, asynchronous.
- `travar`  in  1  lock from game control; while high, presses are tracked but produce no pulse.
- `enter`  out  1  one-cycle accept pulse.
- `tentativa`  out  W  switch value captured at the last accepted press.
- `num_tentativas`  out  $clog2(MAX_TENTATIVAS+1)  accepted-press count, saturating.
- `esgotou`  out  1  high when `num_tentativas == MAX_TENTATIVAS`.

## Operation
- Synchronizers: two-flop chain on `key_enter_n` (reset value 1 = released) giving `key_s`; two-flop chain on each `sw` bit (reset 0) giving `sw_s`.
- Debounce FSM, 16-bit-or-wider counter `cnt` sized for DEBOUNCE_CYCLES:
  - OCIOSO: released-stable. `key_s`=0 → CONF_PRESS, `cnt`←0.
  - CONF_PRESS: `key_s`=1 → OCIOSO (bounce, no pulse). Else if `cnt == DEBOUNCE_CYCLES-1` → PRESSIONADO and accept; else `cnt`++.
  - PRESSIONADO: `key_s`=1 → CONF_SOLTA, `cnt`←0.
  - CONF_SOLTA: `key_s`=0 → PRESSIONADO (no pulse). Else if `cnt == DEBOUNCE_CYCLES-1` → OCIOSO; else `cnt`++.
- Accept (on the CONF_PRESS→PRESSIONADO edge): if `travar`=0 and `esgotou`=0: `enter`←1 for one cycle, `tentativa`←`sw_s`, `num_tentativas`++. Otherwise FSM still advances, outputs unchanged.
- `num_tentativas` saturates at MAX_TENTATIVAS; `esgotou` is combinational from the registered count.
- Reset values: FSM = CONF_SOLTA, `cnt`=0, `enter`=0, `tentativa`=0, `num_tentativas`=0, `esgotou`=0 (1 only if MAX_TENTATIVAS=0, disallowed).
- Reset in CONF_SOLTA means a button held through reset release must be released and re-pressed before any pulse.
- Reset mid-operation: all state cleared immediately and asynchronously; a pulse in flight is dropped.

## Timing
- `key_enter_n` low and stable before edge 0 → `key_s`=0 after edge 1 → CONF_PRESS after edge 2 → `enter` high during the cycle after edge 2+DEBOUNCE_CYCLES, low after the next edge.
- `tentativa` and `num_tentativas` update on the same edge that raises `enter`; stable while `enter` is high.
- Switch changes reach `sw_s` after 2 edges; the value captured is `sw_s` at the accepting edge.
- Minimum press-to-press spacing: DEBOUNCE_CYCLES release + DEBOUNCE_CYCLES press + synchronizer latency.
- `travar` sampled only at the accepting edge; rising or falling at any other time has no effect.

## Configuration
- `ENTRADA_DEBOUNCE_EN` defined: FSM and counter as above.
- Not defined: no counter; OCIOSO→PRESSIONADO directly when `key_s`=0 (accept on that edge, `enter` high the cycle after edge 2), PRESSIONADO→OCIOSO directly when `key_s`=1; CONF states unused, reset state is PRESSIONADO (same held-key-through-reset rule). For simulation and pre-debounced inputs.

## Test plan
- DEBOUNCE_CYCLES=4, sw=6'b101101, clean press held 20 cycles → one `enter` pulse after edge 6, `tentativa`=6'b101101, `num_tentativas`=1.
- Press with bounces of 2 cycles low/1 high for 10 cycles then stable low → exactly one pulse, 4 cycles after final stable low reaches `key_s`.
- MAX_TENTATIVAS=3, five clean presses → pulses on presses 1–3 only, `num_tentativas`=3, `esgotou`=1, `tentativa` keeps press-3 value.
- `travar`=1 during press 2 of 3 → no pulse for press 2, `num_tentativas`=2 after press 3.
- Button held low across `rst` pulse, released, pressed again → no pulse until the second press; `rst` asserted mid-CONF_PRESS → all outputs 0 immediately.
- Build without `ENTRADA_DEBOUNCE_EN`, clean press → `enter` high the cycle after edge 2, one pulse per press.
